universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, minimum 2.
REQ-002 SHALL have parameter AMT_W, default 4: Amount width; 2**AMT_W > WIDTH SHALL hold.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Clear, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port Mode, input, 3 bits: operation select, latched at Start.
REQ-007 SHALL have port Amount, input, AMT_W bits: shift count, latched at Start.
REQ-008 SHALL have port D, input, WIDTH bits: parallel load data.
REQ-009 SHALL have port SerialInLeft, input, 1 bit: MSB fill for logical shift right.
REQ-010 SHALL have port SerialInRight, input, 1 bit: LSB fill for shift left.
REQ-011 SHALL have port Enable, input, 1 bit: shift-step enable; low stalls SHIFT.
REQ-012 SHALL have port Q, output, WIDTH bits: register contents.
REQ-013 SHALL have port QBar, output, WIDTH bits: always bitwise ~Q.
REQ-014 SHALL have port SerialOut, output, 1 bit: registered bit shifted out on the last shift step.
REQ-015 SHALL have port Busy, output, 1 bit: high while in SHIFT.
REQ-016 SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement Mode encoding: 000 hold; 001 parallel load; 010 shift left; 011 logical shift right; 100 rotate left; 101 rotate right; 110 arithmetic shift right (MSB replicated); 111 reserved, treated as hold.
REQ-018 SHALL implement FSM states IDLE and SHIFT only.
REQ-019 IDLE with Start=1 at edge t SHALL behave per Mode:
- load: Q<=D at edge t.
- hold, reserved, or Amount=0: Q unchanged.
- each of these cases: Done=1 for the cycle after edge t; Busy stays 0.
REQ-020 IDLE with Start=1, shift/rotate Mode and Amount=N>0 SHALL latch Mode, set count=N, enter SHIFT, and set Busy=1 at edge t.
REQ-021 In SHIFT, each edge with Enable=1 SHALL:
- perform one 1-bit step of the latched Mode;
- sample the serial fill input at that edge;
- load SerialOut with the bit leaving Q;
- decrement count.
REQ-022 In SHIFT, an edge with Enable=0 SHALL leave Q, count and SerialOut unchanged.
REQ-023 The step taking count from 1 to 0 SHALL return to IDLE, clear Busy and pulse Done for exactly one cycle; with Enable held high, Done follows edge t+N.
REQ-024 Start during SHIFT SHALL be ignored; Mode and Amount changes during SHIFT SHALL have no effect.
REQ-025 Start in the cycle where Done=1 SHALL be accepted (back-to-back operations, no dead cycle).
REQ-026 Amount > WIDTH SHALL be executed literally; shifts saturate to fill values and rotates wrap modulo WIDTH.
REQ-027 SerialOut SHALL change only on shift steps, Clear, or nothing else; it SHALL be unaffected by load.

Reset
REQ-028 Clear=1 at an edge SHALL set Q=0, QBar=all ones, SerialOut=0, Busy=0, Done=0, count=0 and state IDLE, with priority over Start, Enable and any operation in progress.
REQ-029 Clear during SHIFT SHALL abort the operation with no Done pulse.

Verification (WIDTH=8, AMT_W=4)
REQ-030 Clear, then Start Mode=001 D=0xA5 -> Q=0xA5, QBar=0x5A, Done high 1 cycle, Busy never high.
REQ-031 Q=0x81, Start Mode=010 Amount=3 SerialInRight=1 Enable=1 -> Q steps 0x03, 0x07, 0x0F; SerialOut 1, 0, 0; Done one cycle after the 3rd edge.
REQ-032 Q=0x96, Start Mode=110 Amount=2 -> Q=0xCB then 0xE5; Busy high exactly 2 cycles.
REQ-033 Q=0x3C, Start Mode=101 Amount=8 with Enable low for 2 mid-operation cycles -> final Q=0x3C; Busy high 10 cycles; a Start pulse during Busy is ignored.
REQ-034 Q=0xFF, Start Mode=011 Amount=5 SerialInLeft=0, Clear after the 2nd step -> Q=0x00, QBar=0xFF, Busy=0, no Done; next Start Mode=001 D=0x12 is accepted normally.

Source files
------------

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Multi-cycle universal shift register. An operation is requested with Start
// while idle. Load, hold and zero-length shifts finish immediately (Done pulses
// on the next cycle). Shift/rotate operations run one 1-bit step per enabled
// clock until the latched Amount is used up.
//
// Ports
//   Clock         : single clock, rising edge
//   Clear         : synchronous active-high reset, overrides everything
//   Start         : operation request, only looked at while idle
//   Mode[2:0]     : 000 hold, 001 load, 010 shl, 011 lsr, 100 rol,
//                   101 ror, 110 asr, 111 hold (reserved)
//   Amount        : number of 1-bit steps, latched at Start
//   D             : parallel load data
//   SerialInLeft  : MSB fill for logical shift right
//   SerialInRight : LSB fill for shift left
//   Enable        : step enable while shifting (low = stall)
//   Q / QBar      : register contents and its complement
//   SerialOut     : last bit shifted out (registered)
//   Busy          : high while a shift/rotate is in progress
//   Done          : one-cycle completion pulse
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AMT_W-1:0] Amount,
  input  logic [WIDTH-1:0] D,
  input  logic             SerialInLeft,
  input  logic             SerialInRight,
  input  logic             Enable,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBar,
  output logic             SerialOut,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LSR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic [AMT_W-1:0] r_count, w_count_next;
  logic [2:0]       r_mode, w_mode_next;
  logic             r_sout, w_sout_next;
  logic             r_done, w_done_next;

  logic [WIDTH-1:0] w_step_q;
  logic             w_step_out;
  logic             w_shift_mode;

  // Modes 010..110 are the multi-cycle shift/rotate operations.
  assign w_shift_mode = (Mode >= MODE_SHL) && (Mode <= MODE_ASR);

  // One 1-bit step of the latched operation, plus the bit that leaves Q.
  always_comb begin
    w_step_q   = r_q;
    w_step_out = r_sout;
    case (r_mode)
      MODE_SHL: begin
        w_step_q   = {r_q[WIDTH-2:0], SerialInRight};
        w_step_out = r_q[WIDTH-1];
      end
      MODE_LSR: begin
        w_step_q   = {SerialInLeft, r_q[WIDTH-1:1]};
        w_step_out = r_q[0];
      end
      MODE_ROL: begin
        w_step_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_step_out = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_step_q   = {r_q[0], r_q[WIDTH-1:1]};
        w_step_out = r_q[0];
      end
      MODE_ASR: begin
        w_step_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_step_out = r_q[0];
      end
      default: begin
        w_step_q   = r_q;
        w_step_out = r_sout;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_count_next = r_count;
    w_mode_next  = r_mode;
    w_sout_next  = r_sout;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (Mode == MODE_LOAD) begin
            w_q_next    = D;
            w_done_next = 1'b1;
          end else if (w_shift_mode && (Amount != '0)) begin
            w_mode_next  = Mode;
            w_count_next = Amount;
            w_state_next = ST_SHIFT;
          end else begin
            // hold, reserved or a zero-length shift: nothing to do but report
            w_done_next = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (Enable) begin
          w_q_next     = w_step_q;
          w_sout_next  = w_step_out;
          w_count_next = r_count - AMT_W'(1);
          if (r_count == AMT_W'(1)) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_count <= '0;
      r_mode  <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_count <= w_count_next;
      r_mode  <= w_mode_next;
      r_sout  <= w_sout_next;
      r_done  <= w_done_next;
    end
  end

  assign Q         = r_q;
  assign SerialOut = r_sout;
  assign Busy      = (r_state == ST_SHIFT);
  assign Done      = r_done;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qbar
      assign QBar[gi] = ~r_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  logic       Clock;
  logic       Clear;
  logic       Start;
  logic [2:0] Mode;
  logic [3:0] Amount;
  logic [7:0] D;
  logic       SerialInLeft;
  logic       SerialInRight;
  logic       Enable;
  logic [7:0] Q;
  logic [7:0] QBar;
  logic       SerialOut;
  logic       Busy;
  logic       Done;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers, rules applied per edge).
  int m_q, m_so, m_busy, m_done, m_cnt, m_mode;

  universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Mode(Mode), .Amount(Amount),
    .D(D), .SerialInLeft(SerialInLeft), .SerialInRight(SerialInRight),
    .Enable(Enable), .Q(Q), .QBar(QBar), .SerialOut(SerialOut),
    .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Apply one cycle of inputs, clock it, update the model, sample #1 later.
  task automatic step(input int clr, input int st, input int md, input int amt,
                      input int d, input int en, input int sil, input int sir);
    int nq;
    Clear = 1'(clr); Start = 1'(st); Mode = 3'(md); Amount = 4'(amt);
    D = 8'(d); Enable = 1'(en); SerialInLeft = 1'(sil); SerialInRight = 1'(sir);
    @(posedge Clock);
    if (clr != 0) begin
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      m_done = 0;
      if (st != 0) begin
        if (md == 1) begin
          m_q = d & 255; m_done = 1;
        end else if (md >= 2 && md <= 6 && amt != 0) begin
          m_busy = 1; m_cnt = amt; m_mode = md;
        end else begin
          m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (en != 0) begin
        case (m_mode)
          2: begin nq = (m_q * 2 + sir) % 256;            m_so = m_q / 128; end
          3: begin nq = m_q / 2 + sil * 128;              m_so = m_q % 2;   end
          4: begin nq = (m_q * 2) % 256 + m_q / 128;      m_so = m_q / 128; end
          5: begin nq = m_q / 2 + (m_q % 2) * 128;        m_so = m_q % 2;   end
          default: begin nq = m_q / 2 + (m_q / 128) * 128; m_so = m_q % 2; end
        endcase
        m_q = nq;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 3, 8'hFF, 1, 1, 1);
    total++;
    if (Q !== 8'h00 || QBar !== 8'hFF || SerialOut !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset: Q=%h QBar=%h SO=%b Busy=%b Done=%b, want Q=00 QBar=ff SO=0 Busy=0 Done=0",
               Q, QBar, SerialOut, Busy, Done);
    end
    $display("reset: Q=%h QBar=%h", Q, QBar);
  endtask

  task automatic test_load();
    int busy_seen = 0;
    step(0, 1, 1, 0, 8'hA5, 1, 0, 0);
    if (Busy) busy_seen = 1;
    total++;
    if (Q !== 8'hA5 || QBar !== 8'h5A || Done !== 1'b1) begin
      bad++;
      $display("FAIL load: Q=%h QBar=%h Done=%b, want Q=a5 QBar=5a Done=1", Q, QBar, Done);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    if (Busy) busy_seen = 1;
    total++;
    if (Done !== 1'b0 || busy_seen != 0 || SerialOut !== 1'b0) begin
      bad++;
      $display("FAIL load_pulse: Done=%b busy_seen=%0d SO=%b, want Done=0 busy_seen=0 SO=0",
               Done, busy_seen, SerialOut);
    end
    $display("load: Q=%h QBar=%h", Q, QBar);
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_q [3];
    logic       exp_so [3];
    exp_q = '{8'h03, 8'h07, 8'h0F};
    exp_so = '{1'b1, 1'b0, 1'b0};
    step(0, 1, 1, 0, 8'h81, 1, 0, 1);
    step(0, 1, 2, 3, 0, 1, 0, 1);
    total++;
    if (Busy !== 1'b1 || Q !== 8'h81 || Done !== 1'b0) begin
      bad++;
      $display("FAIL shl_start: Busy=%b Q=%h Done=%b, want Busy=1 Q=81 Done=0", Busy, Q, Done);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 1);
      total++;
      if (Q !== exp_q[i] || SerialOut !== exp_so[i] || Done !== (i == 2) || Busy !== (i != 2)) begin
        bad++;
        $display("FAIL shl_step%0d: Q=%h SO=%b Done=%b Busy=%b, want Q=%h SO=%b Done=%b Busy=%b",
                 i, Q, SerialOut, Done, Busy, exp_q[i], exp_so[i], i == 2, i != 2);
      end
      $display("shl step %0d: Q=%h SO=%b", i, Q, SerialOut);
    end
  endtask

  task automatic test_arith_right();
    int busy_cycles = 0;
    step(0, 1, 1, 0, 8'h96, 1, 0, 0);
    step(0, 1, 6, 2, 0, 1, 0, 0);
    if (Busy) busy_cycles++;
    step(0, 0, 0, 0, 0, 1, 0, 0);
    if (Busy) busy_cycles++;
    total++;
    if (Q !== 8'hCB) begin
      bad++;
      $display("FAIL asr_step1: Q=%h, want cb", Q);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    if (Busy) busy_cycles++;
    total++;
    if (Q !== 8'hE5 || Done !== 1'b1 || busy_cycles != 2 || SerialOut !== 1'b1) begin
      bad++;
      $display("FAIL asr_final: Q=%h Done=%b busy_cycles=%0d SO=%b, want Q=e5 Done=1 busy_cycles=2 SO=1",
               Q, Done, busy_cycles, SerialOut);
    end
    $display("asr: Q=%h busy_cycles=%0d", Q, busy_cycles);
  endtask

  task automatic test_rotate_stall();
    int busy_cycles = 0;
    int n = 0;
    step(0, 1, 1, 0, 8'h3C, 1, 0, 0);
    step(0, 1, 5, 8, 0, 1, 0, 0);
    if (Busy) busy_cycles++;
    while (Done !== 1'b1 && n < 20) begin
      // stall two cycles in the middle, and fire a stray Start right after
      if (n == 3 || n == 4) step(0, 0, 0, 0, 0, 0, 1, 1);
      else if (n == 5)      step(0, 1, 1, 15, 8'hFF, 1, 1, 1);
      else                  step(0, 0, 0, 0, 0, 1, 1, 1);
      if (Busy) busy_cycles++;
      n++;
    end
    total++;
    if (Q !== 8'h3C || busy_cycles != 10 || Done !== 1'b1) begin
      bad++;
      $display("FAIL ror_stall: Q=%h busy_cycles=%0d Done=%b, want Q=3c busy_cycles=10 Done=1",
               Q, busy_cycles, Done);
    end
    $display("ror stall: Q=%h busy_cycles=%0d", Q, busy_cycles);
  endtask

  task automatic test_clear_abort();
    int done_seen = 0;
    step(0, 1, 1, 0, 8'hFF, 1, 0, 0);
    step(0, 1, 3, 5, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    total++;
    if (Q !== 8'h3F || SerialOut !== 1'b1 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL lsr_two_steps: Q=%h SO=%b Busy=%b, want Q=3f SO=1 Busy=1", Q, SerialOut, Busy);
    end
    step(1, 0, 0, 0, 0, 1, 0, 0);
    if (Done) done_seen = 1;
    step(0, 0, 0, 0, 0, 1, 0, 0);
    if (Done) done_seen = 1;
    total++;
    if (Q !== 8'h00 || QBar !== 8'hFF || Busy !== 1'b0 || SerialOut !== 1'b0 || done_seen != 0) begin
      bad++;
      $display("FAIL clear_abort: Q=%h QBar=%h Busy=%b SO=%b done_seen=%0d, want 00 ff 0 0 0",
               Q, QBar, Busy, SerialOut, done_seen);
    end
    step(0, 1, 1, 0, 8'h12, 1, 0, 0);
    total++;
    if (Q !== 8'h12 || Done !== 1'b1) begin
      bad++;
      $display("FAIL load_after_clear: Q=%h Done=%b, want Q=12 Done=1", Q, Done);
    end
    $display("clear abort: Q=%h", Q);
  endtask

  task automatic test_back_to_back();
    step(0, 1, 1, 0, 8'h80, 1, 0, 0);
    // Start in the Done cycle must be accepted
    step(0, 1, 4, 1, 0, 1, 0, 0);
    total++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: Busy=%b Done=%b, want Busy=1 Done=0", Busy, Done);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    total++;
    if (Q !== 8'h01 || SerialOut !== 1'b1 || Done !== 1'b1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: Q=%h SO=%b Done=%b Busy=%b, want Q=01 SO=1 Done=1 Busy=0",
               Q, SerialOut, Done, Busy);
    end
    $display("back to back: Q=%h", Q);
  endtask

  task automatic test_random();
    int md, amt, n, clr;
    for (int op = 0; op < 150; op++) begin
      md  = $urandom_range(0, 7);
      amt = $urandom_range(0, 15);
      clr = ($urandom_range(0, 19) == 0) ? 1 : 0;
      step(clr, 1, md, amt, $urandom_range(0, 255), 1, $urandom_range(0, 1), $urandom_range(0, 1));
      n = 0;
      do begin
        total++;
        if (Q !== 8'(m_q) || QBar !== ~8'(m_q) || SerialOut !== 1'(m_so) ||
            Busy !== 1'(m_busy) || Done !== 1'(m_done)) begin
          bad++;
          $display("FAIL random op%0d cyc%0d: Q=%h SO=%b Busy=%b Done=%b QBar=%h, want Q=%h SO=%0d Busy=%0d Done=%0d",
                   op, n, Q, SerialOut, Busy, Done, QBar, m_q, m_so, m_busy, m_done);
        end
        if (m_busy != 0)
          step(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
               $urandom_range(0, 255), ($urandom_range(0, 3) != 0) ? 1 : 0,
               $urandom_range(0, 1), $urandom_range(0, 1));
        n++;
      end while (m_busy != 0 && n < 200);
      if (n >= 200) begin
        total++;
        bad++;
        $display("FAIL random_timeout op%0d: busy still %b after %0d cycles, want idle", op, Busy, n);
      end
      $display("random op%0d mode=%0d amt=%0d Q=%h", op, md, amt, Q);
    end
  endtask

  initial begin
    Clear = 1'b1; Start = 1'b0; Mode = 3'd0; Amount = 4'd0; D = 8'd0;
    Enable = 1'b0; SerialInLeft = 1'b0; SerialInRight = 1'b0;
    m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
    test_reset();
    test_load();
    test_shift_left();
    test_arith_right();
    test_rotate_stall();
    test_clear_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
